// File: rtl/x74191_chain.sv
// Cascaded 74191-style synchronous up/down counter of STAGES 4-bit stages.
// Optional X74191_AUTO_RELOAD_EN: a down-count from zero reloads P (divide-by-(P+1)).
module x74191_chain #(
  parameter int STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ld_n,
  input  logic                cte_n,
  input  logic                d_u,
  input  logic [4*STAGES-1:0] P,
  output logic [4*STAGES-1:0] Q,
  output logic                max_min,
  output logic                rco_n,
  output logic                tc_pulse
);

  localparam int W = 4 * STAGES;
  localparam logic [W-1:0] ALL_ZERO = {W{1'b0}};
  localparam logic [W-1:0] ALL_ONES = {W{1'b1}};

  logic [W-1:0] q_r;
  logic [W-1:0] q_step_s;
  logic [W-1:0] q_next_s;
  logic         max_min_s;
  logic         tc_r;

  assign max_min_s = d_u ? (q_r == ALL_ZERO) : (q_r == ALL_ONES);

  // Per-stage stepping: each stage is enabled only when all lower stages sit at their terminal value.
  always_comb begin
    logic carry_v;
    carry_v  = ~cte_n;
    q_step_s = q_r;
    for (int k = 0; k < STAGES; k++) begin
      if (carry_v) begin
        if (d_u) begin
          q_step_s[4*k +: 4] = q_r[4*k +: 4] - 4'h1;
        end else begin
          q_step_s[4*k +: 4] = q_r[4*k +: 4] + 4'h1;
        end
      end else begin
        q_step_s[4*k +: 4] = q_r[4*k +: 4];
      end
      carry_v = carry_v & (d_u ? (q_r[4*k +: 4] == 4'h0) : (q_r[4*k +: 4] == 4'hF));
    end
  end

  // Next count value, including the optional reload on down-wrap.
  always_comb begin
    q_next_s = q_step_s;
`ifdef X74191_AUTO_RELOAD_EN
    if (d_u && (q_r == ALL_ZERO)) begin
      q_next_s = P;
    end else begin
      q_next_s = q_step_s;
    end
`else
    q_next_s = q_step_s;
`endif
  end

  // Counter state and terminal-count pulse; reset beats load beats count.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_r  <= ALL_ZERO;
      tc_r <= 1'b0;
    end else if (!ld_n) begin
      q_r  <= P;
      tc_r <= 1'b0;
    end else if (!cte_n) begin
      q_r  <= q_next_s;
      tc_r <= max_min_s;
    end else begin
      q_r  <= q_r;
      tc_r <= 1'b0;
    end
  end

  assign Q        = q_r;
  assign tc_pulse = tc_r;
  assign max_min  = max_min_s;
  assign rco_n    = ~(max_min_s & ~cte_n);

endmodule

// File: tb/tb_x74191_chain.sv
// Scoreboard bench for x74191_chain (STAGES = 2): directed plan sequences plus random traffic.
module tb_x74191_chain;

  localparam int STAGES = 2;
  localparam int W = 4 * STAGES;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         ld_n = 1'b1;
  logic         cte_n = 1'b1;
  logic         d_u = 1'b0;
  logic [W-1:0] P = '0;
  logic [W-1:0] Q;
  logic         max_min;
  logic         rco_n;
  logic         tc_pulse;

  typedef struct packed {
    logic [W-1:0] q;
    logic         tc;
  } exp_t;

  exp_t         sb_q[$];
  logic [W-1:0] m_q = '0;
  bit           m_known = 1'b0;
  int           n_cmp = 0;
  int           n_err = 0;

  x74191_chain #(.STAGES(STAGES)) dut (
    .clk(clk), .reset(reset), .ld_n(ld_n), .cte_n(cte_n), .d_u(d_u),
    .P(P), .Q(Q), .max_min(max_min), .rco_n(rco_n), .tc_pulse(tc_pulse)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check combinational flags, predict and compare registered outputs.
  task automatic step(input logic r, input logic l, input logic c, input logic du, input logic [W-1:0] p);
    exp_t e;
    exp_t got;
    logic mm;
    logic exp_rco;
    @(negedge clk);
    reset = r; ld_n = l; cte_n = c; d_u = du; P = p;
    #1;
    mm      = du ? (m_q == {W{1'b0}}) : (m_q == {W{1'b1}});
    exp_rco = ~(mm & ~c);
    if (m_known) begin
      check_val("max_min", {31'd0, max_min}, {31'd0, mm});
      check_val("rco_n", {31'd0, rco_n}, {31'd0, exp_rco});
    end
    if (r) begin
      e.q = '0; e.tc = 1'b0;
    end else if (!l) begin
      e.q = p; e.tc = 1'b0;
    end else if (!c) begin
      e.tc = mm;
      if (du) begin
        if (m_q == {W{1'b0}}) begin
`ifdef X74191_AUTO_RELOAD_EN
          e.q = p;
`else
          e.q = {W{1'b1}};
`endif
        end else begin
          e.q = m_q - 1'b1;
        end
      end else begin
        e.q = m_q + 1'b1;
      end
    end else begin
      e.q = m_q; e.tc = 1'b0;
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check_val("sb_empty", 32'd1, 32'd0);
    end else begin
      got = sb_q.pop_front();
      check_val("Q", {{(32-W){1'b0}}, Q}, {{(32-W){1'b0}}, got.q});
      check_val("tc_pulse", {31'd0, tc_pulse}, {31'd0, got.tc});
      m_q = got.q;
    end
    if (r) m_known = 1'b1;
  endtask

  initial begin
    // Reset with counting down enabled: Q=0, max_min=1, rco_n=0.
    step(1'b1, 1'b1, 1'b0, 1'b1, 8'h00);
    step(1'b1, 1'b1, 1'b0, 1'b1, 8'h00);
    check_val("reset_q", {24'd0, Q}, 32'h00);
    check_val("reset_mm", {31'd0, max_min}, 32'd1);
    check_val("reset_rco", {31'd0, rco_n}, 32'd0);

    // Load 0x12 then count down across a stage borrow.
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'h12);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    check_val("down_borrow", {24'd0, Q}, 32'h0F);

    // Up wrap from FE.
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'hFE);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    check_val("up_wrap", {24'd0, Q}, 32'h01);

    // Load beats count, then reset beats load.
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h40);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h07);
    check_val("ld_prio", {24'd0, Q}, 32'h07);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h07);
    check_val("rst_prio", {24'd0, Q}, 32'h00);

    // Direction flip and hold.
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h05);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 8'h00);
    check_val("hold_q", {24'd0, Q}, 32'h06);
    check_val("hold_rco", {31'd0, rco_n}, 32'd1);

    // Down through zero with P=03 (reload or all-ones depending on build).
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'h03);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 8'h03);

    // Random traffic, biased towards counting with occasional loads and resets.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 11) != 0),
           ($urandom_range(0, 4) == 0), $urandom_range(0, 1),
           (($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 7))));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
